// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state type, funct3 encodings and alignment helper for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        return (funct3[1:0] == 2'd1 && addr[0]) || (funct3[1:0] == 2'd2 && addr != 2'd0);
    endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: EXU request, memory access and WBU response signals of the load/store unit
// master: environment side (EXU, memory, WBU); slave: the lsu itself
interface lsu_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic            in_ren;
    logic            in_wen;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic [4:0]      in_rd;
    logic            mem_valid;
    logic            mem_wen;
    logic [2:0]      mem_readop;
    logic [XLEN-1:0] mem_raddr;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic [4:0]      out_rd;
    logic            out_fault;
    modport master (
        output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd, mem_rdata, out_ready,
        input  in_ready, mem_valid, mem_wen, mem_readop, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        input  out_valid, out_rdata, out_rd, out_fault
    );
    modport slave (
        input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd, mem_rdata, out_ready,
        output in_ready, mem_valid, mem_wen, mem_readop, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
        output out_valid, out_rdata, out_rd, out_fault
    );
endinterface

// File: rtl/lsu_store_align.sv
// lsu_store_align: byte mask and lane-shifted data for sb/sh/sw
// in: funct3, addr[1:0], wdata; out: wmask (upper nibble zero), wdata_sh
module lsu_store_align import lsu_pkg::*; #(parameter int XLEN = 32) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] wdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata_sh
);
    assign wmask    = {4'b0000, (funct3 == SB ? 4'b0001 : funct3 == SH ? 4'b0011 : 4'b1111) << addr};
    assign wdata_sh = wdata << {addr, 3'b000};
endmodule

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit with fault checks, MEM_LAT idle cycles and a one-cycle memory strobe
// ports: clk, rst (sync, active-high), bus (lsu_if.slave: EXU request, memory access, WBU response)
module lsu import lsu_pkg::*; #(
    parameter int MEM_LAT = 2,
    parameter int XLEN    = 32
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    localparam int CW = MEM_LAT > 0 ? $clog2(MEM_LAT + 1) : 1;
    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            hs, fault, wen_q, fault_q;
    logic [2:0]      readop_q;
    logic [XLEN-1:0] addr_q, wdata_q, out_rdata_q, sa_wdata;
    logic [7:0]      wmask_q, sa_wmask;
    logic [4:0]      rd_q, out_rd_q;
    lsu_store_align #(.XLEN(XLEN)) u_align (
        .funct3  (bus.in_funct3),
        .addr    (bus.in_addr[1:0]),
        .wdata   (bus.in_wdata),
        .wmask   (sa_wmask),
        .wdata_sh(sa_wdata)
    );
    assign hs    = bus.in_valid & (state == IDLE) & (bus.in_ren | bus.in_wen);
    assign fault = (bus.in_ren & bus.in_wen)
                 | (bus.in_ren & !(bus.in_funct3 inside {LB, LH, LW, LBU, LHU}))
                 | (bus.in_wen & !(bus.in_funct3 inside {SB, SH, SW}))
                 | is_misaligned(bus.in_funct3, bus.in_addr[1:0]);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = hs ? (fault ? RESP : MEM_LAT == 0 ? ACCESS : WAIT) : IDLE;
            WAIT:    state_n = cnt == '0 ? ACCESS : WAIT;
            ACCESS:  state_n = RESP;
            default: state_n = bus.out_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wen_q       <= 1'b0;
            fault_q     <= 1'b0;
            readop_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rd_q        <= '0;
            out_rdata_q <= '0;
            out_rd_q    <= '0;
        end else begin
            state <= state_n;
            if (state == WAIT) cnt <= cnt - 1'b1;
            if (hs) begin
                cnt         <= CW'(MEM_LAT - 1);
                wen_q       <= bus.in_wen;
                fault_q     <= fault;
                readop_q    <= bus.in_wen ? 3'd0 : bus.in_funct3;
                addr_q      <= bus.in_addr;
                wdata_q     <= sa_wdata;
                wmask_q     <= sa_wmask;
                rd_q        <= bus.in_rd;
                out_rdata_q <= '0;
                out_rd_q    <= '0;
            end
            if (state == ACCESS) begin
                out_rdata_q <= wen_q ? '0 : bus.mem_rdata;
                out_rd_q    <= wen_q ? '0 : rd_q;
            end
        end
    end
    assign bus.in_ready   = state == IDLE;
    assign bus.mem_valid  = state == ACCESS;
    assign bus.mem_wen    = (state == ACCESS) & wen_q;
    assign bus.mem_readop = readop_q;
    assign bus.mem_raddr  = addr_q;
    assign bus.mem_waddr  = {addr_q[XLEN-1:2], 2'b00};
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wmask  = wmask_q;
    assign bus.out_valid  = state == RESP;
    assign bus.out_rdata  = out_rdata_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_fault  = fault_q;
endmodule
